// File: rtl/sys_defs.sv
// Shared system definitions: bus command encodings,
// write-buffer FSM states and the default buffer depth.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic {
    WB_IDLE,
    WB_DRAIN
  } wb_state_t;

  localparam int WB_DEPTH = 4;

endpackage

// File: rtl/dmem_wb_fifo.sv
// Posted-store storage: circular buffer with pointers, count
// and an associative lookup that returns the youngest match.
import sys_defs::*;

module dmem_wb_fifo #(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [29:0] push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic [29:0] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_data,
  output logic [29:0] head_addr,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && valid_q[idx] &&
          (addr_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Data-memory write buffer: posts stores, forwards load hits,
// and drains stores to memory when the port is free.
import sys_defs::*;

module dmem_write_buffer #(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2Dmem_data,
  output logic [31:0] Dmem2proc_data,
  output logic        dmem_stall,
  output logic [1:0]  mem_command,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  wb_state_t   state_q;
  wb_state_t   state_d;
  logic        is_load;
  logic        is_store;
  logic        push;
  logic        pop;
  logic        hit;
  logic [31:0] hit_data;
  logic [29:0] head_addr;
  logic [31:0] head_data;
  logic        full;
  logic        empty;

  assign is_load  = (proc2Dmem_command == BUS_LOAD);
  assign is_store = (proc2Dmem_command == BUS_STORE);
  assign push     = is_store && !full;

  dmem_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (proc2Dmem_addr[31:2]),
    .push_data  (proc2Dmem_data),
    .pop        (pop),
    .lookup_addr(proc2Dmem_addr[31:2]),
    .hit        (hit),
    .hit_data   (hit_data),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    mem_command    = BUS_NONE;
    mem_addr       = '0;
    mem_wdata      = '0;
    Dmem2proc_data = '0;
    dmem_stall     = 1'b0;
    if (is_store) dmem_stall = full;
    if (is_load && hit) Dmem2proc_data = hit_data;
    unique case (state_q)
      WB_IDLE: begin
        if (is_load && !hit) begin
          mem_command    = BUS_LOAD;
          mem_addr       = proc2Dmem_addr;
          Dmem2proc_data = mem_rdata;
          dmem_stall     = !mem_ack;
        end else if (!empty) begin
          mem_command = BUS_STORE;
          mem_addr    = {head_addr, 2'b00};
          mem_wdata   = head_data;
          if (mem_ack) pop     = 1'b1;
          else         state_d = WB_DRAIN;
        end
      end
      WB_DRAIN: begin
        // Store stays on the bus until accepted; misses wait.
        mem_command = BUS_STORE;
        mem_addr    = {head_addr, 2'b00};
        mem_wdata   = head_data;
        if (is_load && !hit) dmem_stall = 1'b1;
        if (mem_ack) begin
          pop     = 1'b1;
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer with a store log
// checked against hand-built enqueue order.
module tb_dmem_write_buffer;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic        clk;
  logic        rst;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2Dmem_data;
  logic [31:0] Dmem2proc_data;
  logic        dmem_stall;
  logic [1:0]  mem_command;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int errors;
  int checks;

  logic [31:0] log_a [$];
  logic [31:0] log_d [$];
  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];

  dmem_write_buffer #(
    .DEPTH(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .proc2Dmem_command(proc2Dmem_command),
    .proc2Dmem_addr   (proc2Dmem_addr),
    .proc2Dmem_data   (proc2Dmem_data),
    .Dmem2proc_data   (Dmem2proc_data),
    .dmem_stall       (dmem_stall),
    .mem_command      (mem_command),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    #4;
    if (!rst && mem_command == C_STORE && mem_ack) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic [1:0] c, input logic [31:0] a,
                     input logic [31:0] d, input logic ack);
    proc2Dmem_command = c;
    proc2Dmem_addr    = a;
    proc2Dmem_data    = d;
    mem_ack           = ack;
  endtask

  task automatic post(input logic [31:0] a, input logic [31:0] d);
    drv(C_STORE, a, d, 1'b0);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic drain_all(input string tag);
    drv(C_NONE, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 20 && dut.u_fifo.count_q != 0; i++) step();
    #1;
    chk({tag, "_cnt"}, 32'(dut.u_fifo.count_q), 32'd0);
    chk({tag, "_st"}, 32'(dut.state_q), 32'd0);
    drv(C_NONE, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    mem_rdata = 32'h0;
    drv(C_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_cmd", 32'(mem_command), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", Dmem2proc_data, 32'h0);
    chk("rst_stall", 32'(dmem_stall), 32'd0);
    step();
    rst = 1'b0;

    // store then forwarded load
    post(32'h100, 32'hAAAA);
    #1 chk("st100_stall", 32'(dmem_stall), 32'd0);
    step();
    drv(C_LOAD, 32'h100, 32'h0, 1'b0);
    #1;
    chk("fwd_data", Dmem2proc_data, 32'hAAAA);
    chk("fwd_stall", 32'(dmem_stall), 32'd0);
    chk("fwd_cmd", 32'(mem_command), 32'(C_STORE));
    step();
    drain_all("d1");

    // youngest match wins
    post(32'h200, 32'h1);
    step();
    post(32'h200, 32'h2);
    #1 chk("st200b_stall", 32'(dmem_stall), 32'd0);
    step();
    drv(C_LOAD, 32'h200, 32'h0, 1'b0);
    #1;
    chk("young_data", Dmem2proc_data, 32'h2);
    chk("young_stall", 32'(dmem_stall), 32'd0);
    drain_all("d2");

    // fill, overflow stall, full with same-cycle pop
    for (int i = 0; i < 4; i++) begin
      post(32'h400 + 32'(4 * i), 32'(i + 1));
      step();
    end
    drv(C_STORE, 32'h410, 32'h5, 1'b0);
    #1;
    chk("full_stall", 32'(dmem_stall), 32'd1);
    chk("full_cnt", 32'(dut.u_fifo.count_q), 32'd4);
    chk("full_maddr", mem_addr, 32'h400);
    chk("full_mdata", mem_wdata, 32'h1);
    step();
    #1 chk("full_hold", 32'(dut.u_fifo.count_q), 32'd4);
    drv(C_STORE, 32'h410, 32'h5, 1'b1);
    #1 chk("fullpop_stall", 32'(dmem_stall), 32'd1);
    step();
    #1 chk("fullpop_cnt", 32'(dut.u_fifo.count_q), 32'd3);
    post(32'h410, 32'h5);
    #1 chk("refill_stall", 32'(dmem_stall), 32'd0);
    step();
    #1 chk("refill_cnt", 32'(dut.u_fifo.count_q), 32'd4);
    drain_all("d3");

    // load miss while draining
    post(32'h500, 32'h7);
    step();
    drv(C_NONE, 32'h0, 32'h0, 1'b0);
    step();
    mem_rdata = 32'h55;
    drv(C_LOAD, 32'h300, 32'h0, 1'b0);
    #1;
    chk("miss_dr_stall", 32'(dmem_stall), 32'd1);
    chk("miss_dr_cmd", 32'(mem_command), 32'(C_STORE));
    chk("miss_dr_addr", mem_addr, 32'h500);
    step();
    #1 chk("miss_dr_stall2", 32'(dmem_stall), 32'd1);
    drv(C_LOAD, 32'h300, 32'h0, 1'b1);
    #1 chk("miss_dr_ack", 32'(dmem_stall), 32'd1);
    step();
    drv(C_LOAD, 32'h300, 32'h0, 1'b0);
    #1;
    chk("ld_cmd", 32'(mem_command), 32'(C_LOAD));
    chk("ld_addr", mem_addr, 32'h300);
    chk("ld_data", Dmem2proc_data, 32'h55);
    chk("ld_stall", 32'(dmem_stall), 32'd1);
    drv(C_LOAD, 32'h300, 32'h0, 1'b1);
    #1;
    chk("ld_ack_stall", 32'(dmem_stall), 32'd0);
    chk("ld_ack_data", Dmem2proc_data, 32'h55);
    step();
    drv(C_NONE, 32'h0, 32'h0, 1'b0);
    mem_rdata = 32'h0;
    step();

    // reset mid-drain discards posted stores
    for (int i = 0; i < 3; i++) begin
      drv(C_STORE, 32'h600 + 32'(4 * i), 32'h60 + 32'(i), 1'b0);
      step();
    end
    drv(C_NONE, 32'h0, 32'h0, 1'b0);
    #1 chk("pre_rst_cmd", 32'(mem_command), 32'(C_STORE));
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd", 32'(mem_command), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_cnt", 32'(dut.u_fifo.count_q), 32'd0);
    chk("mid_rst_stall", 32'(dmem_stall), 32'd0);
    step();
    rst = 1'b0;
    drv(C_NONE, 32'h0, 32'h0, 1'b1);
    repeat (5) step();
    chk("post_rst_log", 32'(log_a.size()), 32'd9);
    drv(C_NONE, 32'h0, 32'h0, 1'b0);

    // back-to-back store/drain wraps pointers
    for (int i = 0; i < 6; i++) begin
      post(32'h700 + 32'(4 * i), 32'h70 + 32'(i));
      mem_ack = 1'b1;
      step();
    end
    drv(C_NONE, 32'h0, 32'h0, 1'b1);
    step();
    #1;
    chk("wrap_cnt", 32'(dut.u_fifo.count_q), 32'd0);
    chk("wrap_head", 32'(dut.u_fifo.head_q), 32'd2);
    chk("wrap_tail", 32'(dut.u_fifo.tail_q), 32'd2);
    drv(C_NONE, 32'h0, 32'h0, 1'b0);
    step();

    chk("log_size", 32'(log_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
      chk($sformatf("log_a%0d", i), log_a[i], exp_a[i]);
      chk($sformatf("log_d%0d", i), log_d[i], exp_d[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_write_buffer.md
DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of posted-store entries (power of two, >=2).
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 proc2Dmem_command  input  2  processor data-port command: BUS_NONE / BUS_LOAD / BUS_STORE.
REQ-005 proc2Dmem_addr  input  32  processor byte address; word-granular, addr[1:0] ignored.
REQ-006 proc2Dmem_data  input  32  store data.
REQ-007 Dmem2proc_data  output  32  load return data, combinational.
REQ-008 dmem_stall  output  1  request not serviced this cycle; processor holds the request.
REQ-009 mem_command  output  2  memory-side command.
REQ-010 mem_addr  output  32  memory-side address.
REQ-011 mem_wdata  output  32  memory-side store data.
REQ-012 mem_rdata  input  32  memory-side load data, valid in the mem_ack cycle.
REQ-013 mem_ack  input  1  memory accepts the current mem_command this cycle.

Function
REQ-014 Circular buffer: head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0; count 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-015 Store, not full: enqueue {addr[31:2], data} at tail at the next posedge; dmem_stall=0.
REQ-016 Store while full: dmem_stall=1, no enqueue, regardless of any same-cycle pop.
REQ-017 Load hit: youngest entry with matching addr[31:2] drives Dmem2proc_data the same cycle; dmem_stall=0; no memory access.
REQ-018 Load miss in IDLE: mem_command=BUS_LOAD, mem_addr=proc2Dmem_addr, Dmem2proc_data=mem_rdata; dmem_stall=!mem_ack.
REQ-019 Load miss in DRAIN: dmem_stall=1; the memory side keeps the pending store.
REQ-020 FSM IDLE: no load miss and buffer non-empty -> present head as BUS_STORE, go to DRAIN at the next posedge unless mem_ack is high the same cycle.
REQ-021 If mem_ack is high in the issue cycle, pop immediately and stay IDLE.
REQ-022 FSM DRAIN: mem_command/addr/wdata held stable from head until mem_ack; on mem_ack, pop head (head+1, count-1) and go to IDLE.
REQ-023 Load miss has priority over starting a drain in IDLE.
REQ-024 Simultaneous enqueue and pop in one cycle: count unchanged, both pointers advance.
REQ-025 Idle outputs: mem_command=BUS_NONE, mem_addr=0, mem_wdata=0, Dmem2proc_data=0.
REQ-026 Store data is never reordered: memory receives stores in enqueue order.

Reset
REQ-027 rst asserted, including mid-DRAIN: head=tail=count=0, all entries invalid, FSM=IDLE, outputs at REQ-025 values, dmem_stall=0.
REQ-028 Posted stores pending at reset are discarded; no memory write is issued after rst.

Structure
REQ-029 Bus command encodings come from the shared sys_defs package.
REQ-030 The FSM state enum (WB_IDLE, WB_DRAIN) and the default DEPTH constant belong in the shared package.
REQ-031 Sub-module dmem_wb_fifo holds the storage, pointers, count and associative youngest-match lookup.
REQ-032 dmem_write_buffer holds the FSM and command muxing.

Verification
REQ-033 Scenario: store 0x100<=0xAAAA, then load 0x100 the next cycle with mem_ack=0 -> Dmem2proc_data=0xAAAA, dmem_stall=0, mem_command never BUS_LOAD.
REQ-034 Scenario: stores 0x200<=1 then 0x200<=2, then load 0x200 -> returns 2 (youngest).
REQ-035 Scenario: five stores with mem_ack=0, DEPTH=4 -> fifth store sees dmem_stall=1; count=4; after mem_ack pulses, memory sees addresses in enqueue order.
REQ-036 Scenario: buffer holds 1 entry in DRAIN; load miss 0x300 -> dmem_stall=1 until mem_ack; then IDLE; load issued with mem_rdata=0x55 -> Dmem2proc_data=0x55.
REQ-037 Scenario: 3 entries queued, rst pulsed mid-DRAIN -> mem_command=BUS_NONE immediately; count=0; no further stores appear.
REQ-038 Scenario: 6 store/drain cycles with mem_ack=1 -> pointers wrap 3->0 with no entry lost.
